mem_sequencer: RTL

- Multi-cycle sequencer for the LC-3b/LC-3X MEM stage. It sits between the decoded control word and the data-memory port.
- Expands each accepted instruction into 0, 1 or 2 memory phases: single access for LDR/LDB/STR/STB/TRAP, two accesses for LDI/STI.
- Also times the LC-3X multi-cycle MUL/DIV ops.
- Drives stall to upstream pipeline stages and emits one completion pulse per retired instruction.

---
 rtl/mem_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: LC-3b/LC-3X MEM-stage sequencer expanding instructions into 0-2 memory phases or a timed MUL/DIV slot.
// Optional memory watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int MULDIV_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [1:0]            in_lc3x,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [1:0]            in_byte_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_byte_enable,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  timeout_err
);
  localparam int CW = $clog2(MULDIV_CYCLES);
  typedef enum logic [2:0] {IDLE, MEM1, MEM2, MD, DONE} state_t;
  typedef enum logic [2:0] {C_PASS, C_READ1, C_WRITE1, C_IND_RD, C_IND_WR, C_MD} cls_t;
  state_t state, state_n;
  cls_t cls, in_cls;
  logic [DATA_WIDTH-1:0] addr, wdata, ptr;
  logic [1:0] be;
  logic [CW-1:0] cnt;
  logic kill, accept, mem_busy, ind, to;
  assign accept   = in_valid && state == IDLE && !flush;
  assign mem_busy = state == MEM1 || state == MEM2;
  assign ind      = cls == C_IND_RD || cls == C_IND_WR;
  always_comb begin
    in_cls = C_PASS;
    case (in_opcode)
      4'b0110, 4'b0010, 4'b1111: in_cls = C_READ1;
      4'b0111, 4'b0011:          in_cls = C_WRITE1;
      4'b1010:                   in_cls = C_IND_RD;
      4'b1011:                   in_cls = C_IND_WR;
      4'b0001:                   in_cls = (in_lc3x == 2'b01 || in_lc3x == 2'b10) ? C_MD : C_PASS;
      default:                   in_cls = C_PASS;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = in_cls == C_MD ? MD : in_cls == C_PASS ? DONE : MEM1;
      MEM1: if (to) state_n = IDLE;
            else if (mem_resp) state_n = (kill || flush) ? IDLE : ind ? MEM2 : DONE;
      MEM2: if (to) state_n = IDLE;
            else if (mem_resp) state_n = (kill || flush) ? IDLE : DONE;
      MD:   state_n = flush ? IDLE : cnt == '0 ? DONE : MD;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Requests are pure decodes of registered state so they stay stable until resp.
  assign in_ready  = state == IDLE;
  assign stall     = state != IDLE;
  assign out_valid = state == DONE && !flush;
  assign mem_read  = (state == MEM1 && cls != C_WRITE1 && cls != C_MD && cls != C_PASS) ||
                     (state == MEM2 && cls == C_IND_RD);
  assign mem_write = (state == MEM1 && cls == C_WRITE1) || (state == MEM2 && cls == C_IND_WR);
  assign mem_addr  = state == MEM2 ? ptr : addr;
  assign mem_wdata = wdata;
  assign mem_byte_enable = mem_write ? be : 2'b11;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cls       <= C_PASS;
      addr      <= '0;
      wdata     <= '0;
      be        <= '0;
      ptr       <= '0;
      out_rdata <= '0;
      kill      <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cls   <= in_cls;
        addr  <= in_addr;
        wdata <= in_wdata;
        be    <= in_byte_en;
      end
      if (state == MEM1 && mem_resp) ptr <= mem_rdata;
      if (mem_read && mem_resp) out_rdata <= mem_rdata;
      kill <= state == IDLE ? 1'b0 : kill | (mem_busy & flush);
      cnt  <= accept ? CW'(MULDIV_CYCLES - 1) : state == MD ? cnt - 1'b1 : cnt;
    end
  end
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd;
  logic err;
  assign to = mem_busy && !mem_resp && wd == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_err = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd  <= (mem_busy && state_n == state) ? wd + 1'b1 : '0;
      err <= err | to;
    end
  end
`else
  assign to = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
